// File: rtl/line_fill_responder_if.sv
// Valid/ready stream bundle used for the line-fill request and response channels.
// master drives tvalid/tdata, slave drives tready.
interface line_fill_responder_if #(
    parameter int DW = 48
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/line_fill_responder.sv
// Line-fill responder: issues fixed-latency line memory reads for cache fill requests
// and returns the lines in order through a credit-limited FWFT response FIFO.
// Optional performance counters are enabled with `define LINE_FILL_PERF_EN.
module line_fill_responder #(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 512,
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    line_fill_responder_if.slave     line_req_stream,
    line_fill_responder_if.master    line_rsp_stream,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rd_data
`ifdef LINE_FILL_PERF_EN
    ,
    output logic [31:0]              perf_req_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam int                IDX_W   = $clog2(MAX_OUTSTANDING);
    localparam int                OCC_W   = IDX_W + 1;
    localparam logic [OCC_W-1:0]  OCC_MAX = OCC_W'(MAX_OUTSTANDING);

    logic                    accept;
    logic                    pop;
    logic                    fifo_wr;
    logic                    fifo_empty;
    logic                    ready_reg;
    logic [OCC_W-1:0]        occ_reg;
    logic [OCC_W-1:0]        occ_next;
    logic [MEM_LATENCY-1:0]  inflight_reg;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [OCC_W-1:0]        wr_ptr_reg;
    logic [OCC_W-1:0]        rd_ptr_reg;
    logic [DATA_WIDTH-1:0]   fifo_mem [MAX_OUTSTANDING];

    // Request side: ready comes only from a flop, never from the consumer's tready.
    assign line_req_stream.tready = ready_reg;
    assign accept      = line_req_stream.tvalid & ready_reg;
    assign mem_rd_en   = accept;
    assign mem_rd_addr = accept ? line_req_stream.tdata : '0;

    // In-flight tracking: one valid bit per memory pipeline stage.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg[0] <= accept;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                inflight_reg[i] <= inflight_reg[i-1];
            end
        end
    end

    assign fifo_wr = inflight_reg[MEM_LATENCY-1];

    // Response FIFO, first-word-fall-through.
    assign fifo_empty             = (wr_ptr_reg == rd_ptr_reg);
    assign line_rsp_stream.tvalid = ~fifo_empty;
    assign line_rsp_stream.tdata  = fifo_mem[rd_ptr_reg[IDX_W-1:0]];
    assign pop                    = ~fifo_empty & line_rsp_stream.tready;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_reg[IDX_W-1:0]] <= mem_rd_data;
        end
    end

    // Credits cover both in-flight reads and FIFO entries, so the FIFO cannot overflow.
    always_comb begin
        occ_next = occ_reg;
        if (accept && !pop) begin
            occ_next = occ_reg + OCC_W'(1);
        end else if (!accept && pop) begin
            occ_next = occ_reg - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + OCC_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + OCC_W'(1);
            end
            occ_reg   <= occ_next;
            ready_reg <= (occ_next < OCC_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && fifo_wr) begin
            assert ((wr_ptr_reg - rd_ptr_reg) < OCC_MAX);
        end
    end

`ifdef LINE_FILL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_req_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept && (perf_req_cnt != 32'hFFFF_FFFF)) begin
                perf_req_cnt <= perf_req_cnt + 32'd1;
            end
            if (line_req_stream.tvalid && !ready_reg && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_line_fill_responder;
    localparam int AW  = 48;
    localparam int DW  = 512;
    localparam int LAT = 2;
    localparam int MO  = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    line_fill_responder_if #(.DW(AW)) req_if ();
    line_fill_responder_if #(.DW(DW)) rsp_if ();

    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
`ifdef LINE_FILL_PERF_EN
    logic [31:0]   perf_req_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    line_fill_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .line_req_stream(req_if),
        .line_rsp_stream(rsp_if),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data)
`ifdef LINE_FILL_PERF_EN
        ,
        .perf_req_cnt(perf_req_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'hA5A5_0000 | {16'h0000, a[15:0]};
        return {16{w}};
    endfunction

    // Line memory with a fixed two-cycle read latency; it is never reset.
    logic          p1_v = 1'b0, p2_v = 1'b0;
    logic [AW-1:0] p1_a = '0, p2_a = '0;
    always @(posedge clk) begin
        p1_v <= mem_rd_en;
        p1_a <= mem_rd_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign mem_rd_data = p2_v ? line_of(p2_a) : {16{32'hDEAD_BEEF}};

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: every accepted request becomes visible 3 cycles later, in order;
    // credits are simply the number of requests not yet consumed.
    typedef struct {
        logic [AW-1:0] a;
        int            rdy;
    } ent_t;
    ent_t q[$];
    int   cyc = 0;
    bit   armed = 1'b0;
    bit   rst_prev_high = 1'b0;
    int   obs_en = 0;
    int   rsp_cycles[$];
    int   m_req = 0;
    int   m_stall = 0;

    always @(negedge clk) begin : model
        bit ev, er, acc, pop;
        ev  = armed && (q.size() > 0) && (q[0].rdy <= cyc);
        er  = armed && rst_prev_high && (q.size() < MO);
        acc = req_if.tvalid && er;
        pop = ev && rsp_if.tready;
        if (armed) begin
            chk1("req_tready", req_if.tready, er);
            chk1("rsp_tvalid", rsp_if.tvalid, ev);
            chk1("mem_rd_en", mem_rd_en, acc);
            chka("mem_rd_addr", mem_rd_addr, acc ? req_if.tdata : '0);
            if (ev) chkd("rsp_tdata", rsp_if.tdata, line_of(q[0].a));
        end
        if (mem_rd_en) obs_en++;
        if (rsp_if.tvalid && rsp_if.tready) rsp_cycles.push_back(cyc);
        if (!rstn) begin
            q.delete();
            rst_prev_high = 1'b0;
            armed   = 1'b1;
            m_req   = 0;
            m_stall = 0;
        end else if (armed) begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{a: req_if.tdata, rdy: cyc + LAT + 1});
            if (acc) m_req++;
            if (req_if.tvalid && !er) m_stall++;
            rst_prev_high = 1'b1;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] lit1234;
        int n, base_en, base_rsp, acc_total;
        lit1234 = {16{32'hA5A5_1234}};
        acc_total = 0;
        req_if.tvalid = 1'b0;
        req_if.tdata  = '0;
        rsp_if.tready = 1'b0;
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        #3;
        chk1("rst_tready", req_if.tready, 1'b0);
        chk1("rst_tvalid", rsp_if.tvalid, 1'b0);
        chk1("rst_mem_rd_en", mem_rd_en, 1'b0);
        step();
        #3 chk1("rst_release_tready", req_if.tready, 1'b1);

        // Single request: mem_rd_en at T, response at T+3.
        step();
        req_if.tvalid = 1'b1; req_if.tdata = 48'h0000_0000_1234; rsp_if.tready = 1'b1;
        #3 chk1("t029_en", mem_rd_en, 1'b1);
        chka("t029_addr", mem_rd_addr, 48'h0000_0000_1234);
        acc_total++;
        step(); req_if.tvalid = 1'b0;
        #3 chk1("t029_t1", rsp_if.tvalid, 1'b0);
        step(); #3 chk1("t029_t2", rsp_if.tvalid, 1'b0);
        step(); #3 chk1("t029_t3", rsp_if.tvalid, 1'b1);
        chkd("t029_data", rsp_if.tdata, lit1234);
        step(); #3 chk1("t029_t4", rsp_if.tvalid, 1'b0);

        // Consumer stalled: only four requests fit.
        rsp_if.tready = 1'b0;
        base_en = obs_en;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            req_if.tvalid = 1'b1;
            req_if.tdata  = AW'(32'h100 + n);
            #3;
            if (req_if.tready) n++;
        end
        acc_total += n;
        chki("t030_accepts", n, 4);
        chk1("t030_tready_low", req_if.tready, 1'b0);
        step();
        chki("t030_rd_pulses", obs_en - base_en, 4);

        // Full, one pop: ready returns one cycle later, one more accept refills.
        base_en = obs_en;
        rsp_if.tready = 1'b1;
        #3 chk1("t032_pop_cycle_tready", req_if.tready, 1'b0);
        chk1("t032_pop_cycle_tvalid", rsp_if.tvalid, 1'b1);
        step(); rsp_if.tready = 1'b0;
        #3 chk1("t032_next_tready", req_if.tready, 1'b1);
        acc_total++;
        step(); req_if.tvalid = 1'b0;
        #3 chk1("t032_refull_tready", req_if.tready, 1'b0);
        chki("t032_one_accept", obs_en - base_en, 1);
        rsp_if.tready = 1'b1;
        repeat (8) step();

        // Streaming 100 requests with an always-ready consumer.
        base_rsp = rsp_cycles.size();
        n = 0;
        for (int k = 0; k < 200 && n < 100; k++) begin
            step();
            req_if.tvalid = 1'b1;
            req_if.tdata  = AW'(n);
            #3;
            if (!req_if.tready) chk1("t031_tready_held", req_if.tready, 1'b1);
            if (req_if.tready) n++;
        end
        acc_total += n;
        step(); req_if.tvalid = 1'b0;
        repeat (6) step();
        chki("t031_rsp_count", rsp_cycles.size() - base_rsp, 100);
        if (rsp_cycles.size() - base_rsp >= 100)
            chki("t031_throughput", rsp_cycles[base_rsp + 99] - rsp_cycles[base_rsp], 99);

        // Reset with two reads in flight and one line in the FIFO.
        rsp_if.tready = 1'b0;
        step(); req_if.tvalid = 1'b1; req_if.tdata = 48'h0AA;
        step(); req_if.tvalid = 1'b0;
        step(); req_if.tvalid = 1'b1; req_if.tdata = 48'h0BB;
        step(); req_if.tdata = 48'h0CC;
        step(); req_if.tvalid = 1'b0; rstn = 1'b0;
        acc_total += 3;
        #3 chk1("t033_fifo_has_entry", rsp_if.tvalid, 1'b1);
        step(); rstn = 1'b1;
        #3 chk1("t033_tvalid_cleared", rsp_if.tvalid, 1'b0);
        base_rsp = rsp_cycles.size();
        rsp_if.tready = 1'b1;
        repeat (4) step();
        chki("t033_no_stale", rsp_cycles.size() - base_rsp, 0);
        req_if.tvalid = 1'b1; req_if.tdata = 48'h777;
        #3 chk1("t033_accept_after_reset", mem_rd_en, 1'b1);
        acc_total++;
        step(); req_if.tvalid = 1'b0;
        repeat (2) step();
        #3 chkd("t033_new_rsp", rsp_if.tdata, line_of(48'h777));
        repeat (4) step();
        chki("t033_one_rsp", rsp_cycles.size() - base_rsp, 1);

        // Random valid/ready traffic against the model.
        n = 0;
        for (int k = 0; k < 60000 && n < 10000; k++) begin
            step();
            req_if.tvalid = ($urandom_range(0, 3) != 0);
            req_if.tdata  = AW'(32'h10000 + n);
            rsp_if.tready = ($urandom_range(0, 9) < 7);
            #3;
            if (req_if.tvalid && req_if.tready) n++;
        end
        acc_total += n;
        chki("t034_requests", n, 10000);
        step(); req_if.tvalid = 1'b0; rsp_if.tready = 1'b1;
        repeat (10) step();
        chki("t034_model_drained", q.size(), 0);
        chki("total_rd_pulses", obs_en, acc_total);
        chki("total_rsp", rsp_cycles.size(), acc_total - 3);
`ifdef LINE_FILL_PERF_EN
        chki("perf_req_cnt", int'(perf_req_cnt), m_req);
        chki("perf_stall_cnt", int'(perf_stall_cnt), m_stall);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
